core_pipe_cf_arbiter: RTL and testbench
=======================================

// Module: core_pipe_cf_arbiter
//
// PURPOSE
//  Arbitrates control flow change requests from decode (s1), execute (s3)
//  and writeback/trap (s4) into one registered request to the fetch stage.
//  Sits between the pipeline stages and core_pipe_fetch.
//  Returns a one-hot ack to the winning stage.
//  Pulses flush strobes for pipeline stages younger than the winner.
//
// PARAMETERS
//  XLEN        64   Register / address width. XL = XLEN-1.
//  CF_CAUSE_W  6    Width of the control flow cause field. CF_CAUSE_R = CF_CAUSE_W-1.
//
// PORTS
//  g_clk          in   1          Global clock.
//  g_reset        in   1          Global reset; synchronous, active-high.
//  s1_cf_valid    in   1          Decode stage cf change request.
//  s1_cf_target   in   XLEN       Decode stage target.
//  s1_cf_cause    in   CF_CAUSE_W Decode stage cause.
//  s1_cf_ack      out  1          Decode stage request accepted.
//  s3_cf_valid/target/cause/ack   Execute stage; same widths and meaning.
//  s4_cf_valid/target/cause/ack   Writeback/trap stage; same widths and meaning.
//  f_cf_valid     out  1          Registered request to fetch.
//  f_cf_target    out  XLEN       Registered target to fetch.
//  f_cf_cause     out  CF_CAUSE_W Registered cause to fetch.
//  f_cf_ack       in   1          Fetch has taken the request.
//  flush_s1       out  1          Kill the s1 instruction (1-cycle pulse).
//  flush_s2       out  1          Kill the s2 instruction (1-cycle pulse).
//  flush_s3       out  1          Kill the s3 instruction (1-cycle pulse).
//
// BEHAVIOUR
//  Reset values: all outputs 0; FSM = IDLE; owner register = NONE.
//  Priority: oldest stage wins, s4 > s3 > s1.
//  Requester rule: a stage holds valid, target and cause stable until its ack.
//  FSM states: IDLE and BUSY.
//  - IDLE: if any sx_cf_valid is set, capture the winner's target, cause
//    and owner ID into registers, then go to BUSY. Otherwise stay in IDLE.
//  - BUSY: f_cf_valid = 1. f_cf_target and f_cf_cause come from registers
//    and stay stable until ack.
//  - BUSY with f_cf_ack = 1: sx_cf_ack = 1 for the owner only, in the same
//    cycle (combinational). Flushes pulse in that cycle. Next state = IDLE.
//  Latency: request in cycle N -> f_cf_valid in cycle N+1 -> earliest ack
//    in N+1.
//  Grant spacing: minimum 2 cycles between consecutive grants, because
//    IDLE is revisited after every ack.
//  Flush on ack, by owner:
//  - s4: flush_s1, flush_s2 and flush_s3 all pulse.
//  - s3: flush_s1 and flush_s2 pulse.
//  - s1: no flush.
//  f_cf_ack while in IDLE is ignored: no ack, no flush.
//  Simultaneous requests: the lower-priority requests get no ack. They keep
//    valid high and are arbitrated again from IDLE, unless they are flushed.
//  Reset mid-operation (BUSY): go to IDLE next cycle.
//  - f_cf_valid drops.
//  - No ack and no flush are issued.
//  - The captured request is discarded.
//  Owner drops valid while BUSY (it was flushed externally): the request to
//    fetch is still completed. The ack is still driven and ignored by the
//    requester.
//
// CONFIGURATION
//  CORE_PIPE_CF_ARB_PREEMPT_EN
//  - Defined: in BUSY with no f_cf_ack, a valid request from a stage of
//    higher priority than the owner replaces the captured target, cause and
//    owner at the next edge. f_cf_valid stays 1.
//  - Defined: the preempted stage gets no ack. Its instruction is killed by
//    the flush that the new owner issues on ack.
//  - Not defined: the registered request stays fixed until f_cf_ack.
//    Higher-priority requests wait until the FSM returns to IDLE.
//
// TESTING
//  1. Lone s1 request, target=0x8000_0100. f_cf_ack held high.
//     -> f_cf_valid in the next cycle with target 0x8000_0100.
//     -> s1_cf_ack pulses in that cycle. No flush.
//  2. s1 and s3 requests in the same cycle, s3 target=0x200.
//     -> s3 wins: f_cf_target=0x200.
//     -> On ack: s3_cf_ack=1, flush_s1=1, flush_s2=1, s1_cf_ack=0.
//  3. f_cf_ack held low for 5 cycles while in BUSY.
//     -> f_cf_valid, target and cause are stable for all 5 cycles.
//     -> A single ack pulse follows when f_cf_ack rises.
//  4. g_reset asserted while BUSY.
//     -> Next cycle: all outputs 0 and FSM in IDLE.
//     -> No sx_cf_ack or flush at any point.
//  5. PREEMPT_EN: s1 owns BUSY, then s4 requests target=0x40 with f_cf_ack=0.
//     -> f_cf_target becomes 0x40 next cycle.
//     -> On ack: s4_cf_ack and all three flushes pulse. s1_cf_ack stays 0.
//     -> Without the macro: 0x0 target of s1 completes first. s4 is granted
//        2 cycles later.
//  6. f_cf_ack pulsed while IDLE.
//     -> No outputs change.

Source files
------------

// File: rtl/core_pipe_cf_arbiter.sv
// Control flow change arbiter: picks the oldest requesting stage and holds one registered request for fetch.
// Optional preemption of a pending request by an older stage: CORE_PIPE_CF_ARB_PREEMPT_EN.
module core_pipe_cf_arbiter #(
  parameter int XLEN       = 64,
  parameter int CF_CAUSE_W = 6
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  input  logic                  s1_cf_valid,
  input  logic [XLEN-1:0]       s1_cf_target,
  input  logic [CF_CAUSE_W-1:0] s1_cf_cause,
  output logic                  s1_cf_ack,
  input  logic                  s3_cf_valid,
  input  logic [XLEN-1:0]       s3_cf_target,
  input  logic [CF_CAUSE_W-1:0] s3_cf_cause,
  output logic                  s3_cf_ack,
  input  logic                  s4_cf_valid,
  input  logic [XLEN-1:0]       s4_cf_target,
  input  logic [CF_CAUSE_W-1:0] s4_cf_cause,
  output logic                  s4_cf_ack,
  output logic                  f_cf_valid,
  output logic [XLEN-1:0]       f_cf_target,
  output logic [CF_CAUSE_W-1:0] f_cf_cause,
  input  logic                  f_cf_ack,
  output logic                  flush_s1,
  output logic                  flush_s2,
  output logic                  flush_s3
);

  // state | meaning
  // IDLE  | no request held; arbitrate incoming requests
  // BUSY  | request held in registers and presented to fetch until f_cf_ack
  typedef enum logic {IDLE, BUSY} state_t;
  // Encoding order doubles as priority order for the preemption compare.
  typedef enum logic [1:0] {OWN_NONE, OWN_S1, OWN_S3, OWN_S4} owner_t;

  state_t                state;
  owner_t                owner;
  owner_t                winner;
  logic [XLEN-1:0]       win_target;
  logic [CF_CAUSE_W-1:0] win_cause;
  logic                  take_ack;
  logic                  preempt;

  always_comb begin
    winner     = OWN_NONE;
    win_target = '0;
    win_cause  = '0;
    if (s4_cf_valid) begin
      winner     = OWN_S4;
      win_target = s4_cf_target;
      win_cause  = s4_cf_cause;
    end else if (s3_cf_valid) begin
      winner     = OWN_S3;
      win_target = s3_cf_target;
      win_cause  = s3_cf_cause;
    end else if (s1_cf_valid) begin
      winner     = OWN_S1;
      win_target = s1_cf_target;
      win_cause  = s1_cf_cause;
    end
  end

  // A reset cycle must never leak an ack or flush, even if fetch acks.
  assign take_ack = (state == BUSY) && f_cf_ack && !g_reset;

`ifdef CORE_PIPE_CF_ARB_PREEMPT_EN
  assign preempt = (state == BUSY) && !f_cf_ack && (winner > owner);
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state       <= IDLE;
      owner       <= OWN_NONE;
      f_cf_valid  <= 1'b0;
      f_cf_target <= '0;
      f_cf_cause  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (winner != OWN_NONE) begin
            state       <= BUSY;
            owner       <= winner;
            f_cf_valid  <= 1'b1;
            f_cf_target <= win_target;
            f_cf_cause  <= win_cause;
          end
        end
        BUSY: begin
          if (f_cf_ack) begin
            state       <= IDLE;
            owner       <= OWN_NONE;
            f_cf_valid  <= 1'b0;
            f_cf_target <= '0;
            f_cf_cause  <= '0;
          end else if (preempt) begin
            owner       <= winner;
            f_cf_target <= win_target;
            f_cf_cause  <= win_cause;
          end
        end
        default: begin
          state      <= IDLE;
          owner      <= OWN_NONE;
          f_cf_valid <= 1'b0;
        end
      endcase
    end
  end

  assign s1_cf_ack = take_ack && (owner == OWN_S1);
  assign s3_cf_ack = take_ack && (owner == OWN_S3);
  assign s4_cf_ack = take_ack && (owner == OWN_S4);

  // Everything younger than the winning stage is killed.
  assign flush_s1  = take_ack && ((owner == OWN_S3) || (owner == OWN_S4));
  assign flush_s2  = take_ack && ((owner == OWN_S3) || (owner == OWN_S4));
  assign flush_s3  = take_ack && (owner == OWN_S4);

endmodule

// File: tb/tb_core_pipe_cf_arbiter.sv
// Bench for core_pipe_cf_arbiter: request-level model plus directed scenarios with literal expectations.
// Expectations follow CORE_PIPE_CF_ARB_PREEMPT_EN when it is defined for the build.
module tb_core_pipe_cf_arbiter;
  localparam int XLEN = 64;
  localparam int CW   = 6;

  logic            g_clk, g_reset;
  logic            s1_cf_valid, s3_cf_valid, s4_cf_valid;
  logic [XLEN-1:0] s1_cf_target, s3_cf_target, s4_cf_target;
  logic [CW-1:0]   s1_cf_cause, s3_cf_cause, s4_cf_cause;
  logic            s1_cf_ack, s3_cf_ack, s4_cf_ack;
  logic            f_cf_valid, f_cf_ack;
  logic [XLEN-1:0] f_cf_target;
  logic [CW-1:0]   f_cf_cause;
  logic            flush_s1, flush_s2, flush_s3;

  core_pipe_cf_arbiter #(.XLEN(XLEN), .CF_CAUSE_W(CW)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .s1_cf_valid(s1_cf_valid), .s1_cf_target(s1_cf_target), .s1_cf_cause(s1_cf_cause), .s1_cf_ack(s1_cf_ack),
    .s3_cf_valid(s3_cf_valid), .s3_cf_target(s3_cf_target), .s3_cf_cause(s3_cf_cause), .s3_cf_ack(s3_cf_ack),
    .s4_cf_valid(s4_cf_valid), .s4_cf_target(s4_cf_target), .s4_cf_cause(s4_cf_cause), .s4_cf_ack(s4_cf_ack),
    .f_cf_valid(f_cf_valid), .f_cf_target(f_cf_target), .f_cf_cause(f_cf_cause), .f_cf_ack(f_cf_ack),
    .flush_s1(flush_s1), .flush_s2(flush_s2), .flush_s3(flush_s3)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: the one request currently held for fetch (age rank 0 = none, 1 = s1, 2 = s3, 3 = s4).
  int              m_busy  = 0;
  int              m_rank  = 0;
  logic [XLEN-1:0] m_tgt   = '0;
  logic [CW-1:0]   m_cause = '0;
  logic            a1, a3, a4;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oldest_rank();
    int r = 0;
    if (s1_cf_valid) r = 1;
    if (s3_cf_valid) r = 2;
    if (s4_cf_valid) r = 3;
    return r;
  endfunction

  task automatic take_request(input int r);
    m_rank = r;
    case (r)
      1: begin m_tgt = s1_cf_target; m_cause = s1_cf_cause; end
      2: begin m_tgt = s3_cf_target; m_cause = s3_cf_cause; end
      default: begin m_tgt = s4_cf_target; m_cause = s4_cf_cause; end
    endcase
  endtask

  task automatic compare_model();
    logic acked;
    acked = (m_busy != 0) && f_cf_ack && !g_reset;
    chk("f_cf_valid",  f_cf_valid,  64'(m_busy != 0));
    chk("f_cf_target", f_cf_target, (m_busy != 0) ? m_tgt : 64'd0);
    chk("f_cf_cause",  f_cf_cause,  (m_busy != 0) ? 64'(m_cause) : 64'd0);
    chk("s1_cf_ack",   s1_cf_ack,   64'(acked && m_rank == 1));
    chk("s3_cf_ack",   s3_cf_ack,   64'(acked && m_rank == 2));
    chk("s4_cf_ack",   s4_cf_ack,   64'(acked && m_rank == 3));
    chk("flush_s1",    flush_s1,    64'(acked && m_rank >= 2));
    chk("flush_s2",    flush_s2,    64'(acked && m_rank >= 2));
    chk("flush_s3",    flush_s3,    64'(acked && m_rank == 3));
  endtask

  task automatic model_edge();
    int w;
    w = oldest_rank();
    if (g_reset) begin
      m_busy = 0; m_rank = 0; m_tgt = '0; m_cause = '0;
    end else if (m_busy == 0) begin
      if (w != 0) begin m_busy = 1; take_request(w); end
    end else if (f_cf_ack) begin
      m_busy = 0; m_rank = 0; m_tgt = '0; m_cause = '0;
    end
`ifdef CORE_PIPE_CF_ARB_PREEMPT_EN
    else if (w > m_rank) take_request(w);
`endif
  endtask

  task automatic at_neg();
    @(negedge g_clk);
    compare_model();
    a1 = s1_cf_ack; a3 = s3_cf_ack; a4 = s4_cf_ack;
  endtask

  // Requesters release their request after seeing their ack.
  task automatic to_pos();
    @(posedge g_clk);
    model_edge();
    #1;
    if (a1) s1_cf_valid = 1'b0;
    if (a3) s3_cf_valid = 1'b0;
    if (a4) s4_cf_valid = 1'b0;
  endtask

  task automatic cyc();
    at_neg();
    to_pos();
  endtask

  initial begin
    g_reset = 1'b1; f_cf_ack = 1'b0;
    s1_cf_valid = 1'b0; s1_cf_target = '0; s1_cf_cause = '0;
    s3_cf_valid = 1'b0; s3_cf_target = '0; s3_cf_cause = '0;
    s4_cf_valid = 1'b0; s4_cf_target = '0; s4_cf_cause = '0;
    a1 = 1'b0; a3 = 1'b0; a4 = 1'b0;
    at_neg();
    chk("reset_f_valid", f_cf_valid, 0);
    chk("reset_target", f_cf_target, 0);
    to_pos();
    cyc();
    g_reset = 1'b0;
    cyc();

    // 1: lone s1 request, fetch always ready
    f_cf_ack = 1'b1;
    s1_cf_valid = 1'b1; s1_cf_target = 64'h8000_0100; s1_cf_cause = 6'd3;
    at_neg();
    chk("t1_no_early_valid", f_cf_valid, 0);
    to_pos();
    at_neg();
    chk("t1_valid", f_cf_valid, 1);
    chk("t1_target", f_cf_target, 64'h8000_0100);
    chk("t1_s1_ack", s1_cf_ack, 1);
    chk("t1_no_flush", {flush_s1, flush_s2, flush_s3}, 0);
    to_pos();
    cyc();

    // 2: s1 and s3 together; s3 wins, s1 keeps requesting and wins next
    s1_cf_valid = 1'b1; s1_cf_target = 64'h100; s1_cf_cause = 6'd1;
    s3_cf_valid = 1'b1; s3_cf_target = 64'h200; s3_cf_cause = 6'd2;
    cyc();
    at_neg();
    chk("t2_target", f_cf_target, 64'h200);
    chk("t2_s3_ack", s3_cf_ack, 1);
    chk("t2_s1_ack", s1_cf_ack, 0);
    chk("t2_flush", {flush_s1, flush_s2, flush_s3}, 3'b110);
    to_pos();
    cyc();
    at_neg();
    chk("t2_rearb_target", f_cf_target, 64'h100);
    chk("t2_rearb_s1_ack", s1_cf_ack, 1);
    to_pos();
    f_cf_ack = 1'b0;
    cyc();

    // 3: fetch stalls five cycles
    s4_cf_valid = 1'b1; s4_cf_target = 64'h300; s4_cf_cause = 6'd5;
    cyc();
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("t3_stall_valid", f_cf_valid, 1);
      chk("t3_stall_target", f_cf_target, 64'h300);
      chk("t3_stall_cause", f_cf_cause, 5);
      chk("t3_stall_no_ack", s4_cf_ack, 0);
      to_pos();
    end
    f_cf_ack = 1'b1;
    at_neg();
    chk("t3_ack", s4_cf_ack, 1);
    to_pos();
    at_neg();
    chk("t3_single_ack", s4_cf_ack, 0);
    to_pos();
    f_cf_ack = 1'b0;

    // 4: reset while BUSY, with fetch acking in the reset cycle
    s3_cf_valid = 1'b1; s3_cf_target = 64'h400; s3_cf_cause = 6'd4;
    cyc();
    at_neg();
    chk("t4_busy", f_cf_valid, 1);
    to_pos();
    g_reset = 1'b1; f_cf_ack = 1'b1;
    at_neg();
    chk("t4_rst_no_ack", s3_cf_ack, 0);
    chk("t4_rst_no_flush", {flush_s1, flush_s2, flush_s3}, 0);
    to_pos();
    g_reset = 1'b0; f_cf_ack = 1'b0; s3_cf_valid = 1'b0;
    at_neg();
    chk("t4_after_valid", f_cf_valid, 0);
    chk("t4_after_target", f_cf_target, 0);
    to_pos();
    cyc();

    // 5: s1 owns, s4 arrives while fetch is stalled
    s1_cf_valid = 1'b1; s1_cf_target = 64'h0; s1_cf_cause = 6'd7;
    cyc();
    s4_cf_valid = 1'b1; s4_cf_target = 64'h40; s4_cf_cause = 6'd9;
    at_neg();
    chk("t5_s1_owns", f_cf_target, 64'h0);
    chk("t5_s1_cause", f_cf_cause, 7);
    to_pos();
    at_neg();
`ifdef CORE_PIPE_CF_ARB_PREEMPT_EN
    chk("t5_preempt_target", f_cf_target, 64'h40);
`else
    chk("t5_held_target", f_cf_target, 64'h0);
`endif
    to_pos();
    f_cf_ack = 1'b1;
    at_neg();
`ifdef CORE_PIPE_CF_ARB_PREEMPT_EN
    chk("t5_s4_ack", s4_cf_ack, 1);
    chk("t5_s1_no_ack", s1_cf_ack, 0);
    chk("t5_flush_all", {flush_s1, flush_s2, flush_s3}, 3'b111);
`else
    chk("t5_s1_ack_first", s1_cf_ack, 1);
    chk("t5_no_flush", {flush_s1, flush_s2, flush_s3}, 0);
`endif
    to_pos();
    s1_cf_valid = 1'b0;
    cyc();
    at_neg();
`ifdef CORE_PIPE_CF_ARB_PREEMPT_EN
    chk("t5_idle_after", f_cf_valid, 0);
`else
    chk("t5_s4_later_target", f_cf_target, 64'h40);
    chk("t5_s4_later_ack", s4_cf_ack, 1);
    chk("t5_s4_later_flush", {flush_s1, flush_s2, flush_s3}, 3'b111);
`endif
    to_pos();
    f_cf_ack = 1'b0;
    cyc();

    // 6: ack pulse while idle
    f_cf_ack = 1'b1;
    at_neg();
    chk("t6_idle_valid", f_cf_valid, 0);
    chk("t6_idle_acks", {s1_cf_ack, s3_cf_ack, s4_cf_ack}, 0);
    chk("t6_idle_flush", {flush_s1, flush_s2, flush_s3}, 0);
    to_pos();
    f_cf_ack = 1'b0;
    cyc();

    // 7: owner withdraws while BUSY; the request still completes
    s3_cf_valid = 1'b1; s3_cf_target = 64'h500; s3_cf_cause = 6'd2;
    cyc();
    s3_cf_valid = 1'b0;
    cyc();
    f_cf_ack = 1'b1;
    at_neg();
    chk("t7_target", f_cf_target, 64'h500);
    chk("t7_s3_ack", s3_cf_ack, 1);
    chk("t7_flush", {flush_s1, flush_s2, flush_s3}, 3'b110);
    to_pos();
    f_cf_ack = 1'b0;
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
